// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks destination/Tnew tags for E, M and W,
// raises stall on unresolved Tuse/Tnew conflicts and selects forwarding paths.
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [1:0] tnew_d,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] a3_d,
    output logic       stall,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e
);

    logic [4:0] rs_e, rt_e, a3_e, a3_m, a3_w;
    logic [1:0] tnew_e, tnew_m;

    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    // A Tuse of 3 marks the operand as unused; register 0 is hardwired and never conflicts.
    function automatic logic src_stall(input logic [4:0] r, input logic [1:0] tuse,
                                       input logic [4:0] ae, input logic [1:0] te,
                                       input logic [4:0] am, input logic [1:0] tm);
        if (r == 5'd0 || tuse == 2'd3)
            return 1'b0;
        return ((r == ae) && (tuse < te)) || ((r == am) && (tuse < tm));
    endfunction

    function automatic logic [1:0] sel_d(input logic [4:0] r,
                                         input logic [4:0] ae, input logic [1:0] te,
                                         input logic [4:0] am, input logic [1:0] tm,
                                         input logic [4:0] aw);
        if (r == ae && ae != 5'd0 && te == 2'd0)
            return 2'd1;
        else if (r == am && am != 5'd0 && tm == 2'd0)
            return 2'd2;
        else if (r == aw && aw != 5'd0)
            return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic [4:0] r,
                                         input logic [4:0] am, input logic [1:0] tm,
                                         input logic [4:0] aw);
        if (r == am && am != 5'd0 && tm == 2'd0)
            return 2'd1;
        else if (r == aw && aw != 5'd0)
            return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        stall    = src_stall(rs_d, tuse_rs_d, a3_e, tnew_e, a3_m, tnew_m)
                 | src_stall(rt_d, tuse_rt_d, a3_e, tnew_e, a3_m, tnew_m);
        fwd_rs_d = sel_d(rs_d, a3_e, tnew_e, a3_m, tnew_m, a3_w);
        fwd_rt_d = sel_d(rt_d, a3_e, tnew_e, a3_m, tnew_m, a3_w);
        fwd_rs_e = sel_e(rs_e, a3_m, tnew_m, a3_w);
        fwd_rt_e = sel_e(rt_e, a3_m, tnew_m, a3_w);
    end

    // D->E loads a bubble on stall; E->M->W always advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_e   <= '0;
            rt_e   <= '0;
            a3_e   <= '0;
            tnew_e <= '0;
            a3_m   <= '0;
            tnew_m <= '0;
            a3_w   <= '0;
        end else begin
            if (stall) begin
                rs_e   <= '0;
                rt_e   <= '0;
                a3_e   <= '0;
                tnew_e <= '0;
            end else begin
                rs_e   <= rs_d;
                rt_e   <= rt_d;
                a3_e   <= a3_d;
                tnew_e <= tnew_d;
            end
            a3_m   <= a3_e;
            tnew_m <= sat_dec(tnew_e);
            a3_w   <= a3_m;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic checked against
// a queue model of in-flight instructions whose remaining Tnew is derived from age.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] tuse_rs_d = '0, tuse_rt_d = '0, tnew_d = '0;
    logic [4:0] rs_d = '0, rt_d = '0, a3_d = '0;
    logic       stall;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int rs;
        int rt;
        int a3;
        int tnew;
    } instr_t;

    instr_t pipe[$];   // index 0 = E (youngest), 1 = M, 2 = W

    hazard_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .tuse_rs_d(tuse_rs_d),
        .tuse_rt_d(tuse_rt_d),
        .tnew_d   (tnew_d),
        .rs_d     (rs_d),
        .rt_d     (rt_d),
        .a3_d     (a3_d),
        .stall    (stall),
        .fwd_rs_d (fwd_rs_d),
        .fwd_rt_d (fwd_rt_d),
        .fwd_rs_e (fwd_rs_e),
        .fwd_rt_e (fwd_rt_e)
    );

    always #5 clk = ~clk;

    function automatic int remaining(int age);
        int r;
        r = pipe[age].tnew - age;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit m_src_stall(int r, int tuse);
        if (r == 0 || tuse == 3)
            return 1'b0;
        return (r == pipe[0].a3 && tuse < remaining(0)) ||
               (r == pipe[1].a3 && tuse < remaining(1));
    endfunction

    function automatic int m_fwd_d(int r);
        if (r == 0) return 0;
        if (r == pipe[0].a3 && remaining(0) == 0) return 1;
        if (r == pipe[1].a3 && remaining(1) == 0) return 2;
        if (r == pipe[2].a3) return 3;
        return 0;
    endfunction

    function automatic int m_fwd_e(int r);
        if (r == 0) return 0;
        if (r == pipe[1].a3 && remaining(1) == 0) return 1;
        if (r == pipe[2].a3) return 2;
        return 0;
    endfunction

    function automatic bit m_stall();
        return m_src_stall(int'(rs_d), int'(tuse_rs_d)) ||
               m_src_stall(int'(rt_d), int'(tuse_rt_d));
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic flush_model();
        instr_t b;
        b = '{0, 0, 0, 0};
        pipe.delete();
        repeat (3) pipe.push_back(b);
    endtask

    // Apply D-stage inputs mid-cycle and compare every output with the model.
    task automatic drive(input int rs, input int tu_rs, input int rt, input int tu_rt,
                         input int a3, input int tn);
        rs_d = 5'(rs); tuse_rs_d = 2'(tu_rs);
        rt_d = 5'(rt); tuse_rt_d = 2'(tu_rt);
        a3_d = 5'(a3); tnew_d = 2'(tn);
        #1;
        chk("stall",    {1'b0, stall}, {1'b0, m_stall()});
        chk("fwd_rs_d", fwd_rs_d, 2'(m_fwd_d(rs)));
        chk("fwd_rt_d", fwd_rt_d, 2'(m_fwd_d(rt)));
        chk("fwd_rs_e", fwd_rs_e, 2'(m_fwd_e(pipe[0].rs)));
        chk("fwd_rt_e", fwd_rt_e, 2'(m_fwd_e(pipe[0].rt)));
    endtask

    task automatic tick(input bit r);
        instr_t nxt;
        bit     s;
        reset = r;
        s = m_stall();
        nxt = s ? '{0, 0, 0, 0} : '{int'(rs_d), int'(rt_d), int'(a3_d), int'(tnew_d)};
        @(posedge clk);
        if (r) begin
            flush_model();
        end else begin
            pipe.push_front(nxt);
            void'(pipe.pop_back());
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic nop();
        drive(0, 3, 0, 3, 0, 0);
        tick(0);
    endtask

    initial begin
        flush_model();
        @(negedge clk);
        drive(0, 3, 0, 3, 0, 0);
        tick(1);

        // Post-reset: nonzero D registers still see no hazard
        drive(8, 0, 9, 0, 10, 2);
        chk("rst_stall", {1'b0, stall}, 2'd0);
        chk("rst_fwd_rs_d", fwd_rs_d, 2'd0);
        chk("rst_fwd_rt_d", fwd_rt_d, 2'd0);
        tick(1);

        // lw $8 -> addu rs=$8 tuse=1: one stall, then W forward in E
        drive(0, 3, 0, 3, 8, 2); tick(0);
        drive(8, 1, 0, 3, 10, 1);
        chk("lw_addu_stall1", {1'b0, stall}, 2'd1);
        tick(0);
        drive(8, 1, 0, 3, 10, 1);
        chk("lw_addu_stall_clear", {1'b0, stall}, 2'd0);
        tick(0);
        drive(0, 3, 0, 3, 0, 0);
        chk("lw_addu_fwd_e_w", fwd_rs_e, 2'd2);
        tick(0);
        repeat (3) nop();

        // lw $8 -> beq rs=$8 tuse=0: two stalls, then W forward in D
        drive(0, 3, 0, 3, 8, 2); tick(0);
        drive(8, 0, 0, 3, 0, 0);
        chk("lw_beq_stall1", {1'b0, stall}, 2'd1);
        tick(0);
        drive(8, 0, 0, 3, 0, 0);
        chk("lw_beq_stall2", {1'b0, stall}, 2'd1);
        tick(0);
        drive(8, 0, 0, 3, 0, 0);
        chk("lw_beq_stall_clear", {1'b0, stall}, 2'd0);
        chk("lw_beq_fwd_d_w", fwd_rs_d, 2'd3);
        tick(0);
        repeat (3) nop();

        // addu $5 -> sw rt=$5 tuse=2: no stall, M forward in E
        drive(0, 3, 0, 3, 5, 1); tick(0);
        drive(0, 3, 5, 2, 0, 0);
        chk("addu_sw_nostall", {1'b0, stall}, 2'd0);
        tick(0);
        drive(0, 3, 0, 3, 0, 0);
        chk("addu_sw_fwd_e_m", fwd_rt_e, 2'd1);
        tick(0);
        repeat (3) nop();

        // lui $9 -> jr $9: E forward; then $9 in E, M and W: E still wins
        drive(0, 3, 0, 3, 9, 0); tick(0);
        drive(9, 0, 0, 3, 0, 0);
        chk("lui_jr_nostall", {1'b0, stall}, 2'd0);
        chk("lui_jr_fwd_e", fwd_rs_d, 2'd1);
        tick(0);
        repeat (3) begin
            drive(0, 3, 0, 3, 9, 0); tick(0);
        end
        drive(9, 0, 0, 3, 0, 0);
        chk("prio_e_wins", fwd_rs_d, 2'd1);
        tick(0);
        repeat (3) nop();

        // Register 0 never matches
        drive(0, 3, 0, 3, 0, 2); tick(0);
        drive(0, 0, 0, 0, 0, 0);
        chk("r0_stall", {1'b0, stall}, 2'd0);
        chk("r0_fwd_rs_d", fwd_rs_d, 2'd0);
        tick(0);

        // Reset mid-stall clears every tag
        drive(0, 3, 0, 3, 8, 2); tick(0);
        drive(8, 0, 0, 3, 0, 0);
        chk("midstall_before", {1'b0, stall}, 2'd1);
        tick(1);
        drive(8, 0, 8, 0, 0, 0);
        chk("midstall_after_stall", {1'b0, stall}, 2'd0);
        chk("midstall_after_fwd_rs_d", fwd_rs_d, 2'd0);
        chk("midstall_after_fwd_rs_e", fwd_rs_e, 2'd0);
        tick(0);
        drive(0, 3, 0, 3, 0, 0);
        chk("midstall_tags_zero_e", fwd_rs_e, 2'd0);
        tick(0);

        // Random traffic on a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
            tick(($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; clears all stage tags.
REQ-004 tuse_rs_d  input  2  D-stage Tuse for rs (0..2; 3 = operand unused).
REQ-005 tuse_rt_d  input  2  D-stage Tuse for rt (0..2; 3 = operand unused).
REQ-006 tnew_d  input  2  Tnew of the D-stage instruction, measured from E-stage entry (0..2).
REQ-007 rs_d, rt_d  input  5 each  D-stage source register numbers.
REQ-008 a3_d  input  5  D-stage destination register; 0 when the instruction writes no register.
REQ-009 stall  output  1  freeze PC and D register, insert bubble into E.
REQ-010 fwd_rs_d, fwd_rt_d  output  2 each  D-stage operand select: 0 regfile, 1 from E, 2 from M, 3 from W.
REQ-011 fwd_rs_e, fwd_rt_e  output  2 each  E-stage operand select: 0 pipeline register, 1 from M, 2 from W.

Function
REQ-012 The block SHALL hold registered tags per stage: E {rs, rt, a3, tnew}, M {a3, tnew}, W {a3}.
REQ-013 Each clk edge without stall: E tag <= {rs_d, rt_d, a3_d, tnew_d}; M <= {a3_E, sat_dec(tnew_E)}; W <= {a3_M}.
REQ-014 sat_dec(x) SHALL be x-1 for x>0 and 0 for x=0; W-stage Tnew is always 0 (not stored).
REQ-015 On a clk edge with stall=1: E tag SHALL load a bubble {0,0,0,0}; M and W SHALL advance per REQ-013.
REQ-016 stall SHALL be combinational from current tags and D inputs: asserted iff, for any source S in {rs,rt} with reg_S_d != 0 and tuse_S_d != 3, (reg_S_d == a3_E and tuse_S_d < tnew_E) or (reg_S_d == a3_M and tuse_S_d < tnew_M).
REQ-017 tuse = 3 SHALL never cause a stall.
REQ-018 fwd_S_d SHALL be: 1 if reg_S_d == a3_E, a3_E != 0, tnew_E == 0; else 2 if reg_S_d == a3_M, a3_M != 0, tnew_M == 0; else 3 if reg_S_d == a3_W, a3_W != 0; else 0.
REQ-019 Forwarding priority SHALL be E over M over W (youngest producer wins).
REQ-020 fwd_S_e SHALL be: 1 if rs/rt_E == a3_M, a3_M != 0, tnew_M == 0; else 2 if == a3_W, a3_W != 0; else 0.
REQ-021 Register 0 SHALL never match: no stall, no forward, regardless of tags.
REQ-022 When stall=1, fwd_*_d values are don't-care for the consumer, but the block SHALL still drive them per REQ-018.
REQ-023 Consecutive stalls SHALL be allowed; each cycle inserts one further bubble until REQ-016 clears.
REQ-024 Maximum stall length for a single dependency SHALL be 2 cycles (lw, tnew_d=2, consumer tuse=0).

Reset
REQ-025 On reset=1 at a clk edge, all E/M/W tags SHALL clear to 0 (bubble), overriding stall.
REQ-026 In the cycle after reset: stall=0 and all fwd_* = 0, for any D inputs with nonzero registers.
REQ-027 Reset asserted mid-stall SHALL terminate the stall; no stale tag survives.

Verification
REQ-028 lw $8 (a3_d=8, tnew_d=2), then addu with rs_d=8, tuse_rs_d=1 -> stall=1 for 1 cycle, then fwd_rs_e=2 (W) when addu reaches E.
REQ-029 lw $8, then beq with rs_d=8, tuse_rs_d=0 -> stall=1 for 2 consecutive cycles, then fwd_rs_d=3 (W).
REQ-030 addu $5 (tnew_d=1), then sw with rt_d=5, tuse_rt_d=2 -> stall=0; sw in E gets fwd_rt_e=1 (M).
REQ-031 lui $9 (tnew_d=0) followed by jr $9 (tuse=0) -> stall=0, fwd_rs_d=1 (E); ori $9 in E and M and W -> fwd_rs_d=1 (E wins).
REQ-032 Producer a3_d=0 (e.g. sw, nop), consumer rs_d=0 -> stall=0, fwd=0 throughout.
REQ-033 Assert reset while lw $8 in E and beq $8 in D -> next cycle stall=0, all fwd_*=0, tags zero.
